// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX field parser: beat kinds, parser
// states, error codes and default delimiter bytes.
package fix_pkg;

  typedef enum logic [1:0] {
    VALUE_BYTE = 2'd0,
    TAG_DONE   = 2'd1,
    FIELD_END  = 2'd2,
    ERROR      = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    IDLE,
    TAG,
    VALUE,
    ERR
  } state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_EMPTY_TAG = 3'd1;
  localparam logic [2:0] ERR_TAG_OVF   = 3'd2;
  localparam logic [2:0] ERR_BAD_TAG   = 3'd3;
  localparam logic [2:0] ERR_VAL_OVF   = 3'd4;
  localparam logic [2:0] ERR_EMPTY_VAL = 3'd5;

  localparam logic [7:0] SOH_DEF = 8'h01;
  localparam logic [7:0] SEP_DEF = 8'h3D;

endpackage

// File: rtl/fix_tag_accum.sv
// ASCII-decimal tag accumulator: digit detect, tag*10+digit, digit count and
// overflow flag. A restart makes the current byte behave as the first digit.
module fix_tag_accum
  import fix_pkg::*;
#(
  parameter int TAG_W          = 17,
  parameter int MAX_TAG_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             load,
  input  logic             clear,
  input  logic [7:0]       data,
  output logic             is_digit,
  output logic             ovf,
  output logic             empty,
  output logic [TAG_W-1:0] tag
);

  localparam int CNT_W = $clog2(MAX_TAG_DIGITS + 1);

  logic [TAG_W-1:0] acc;
  logic [CNT_W-1:0] digits;
  logic [TAG_W-1:0] base_tag;
  logic [CNT_W-1:0] base_digits;
  logic [TAG_W-1:0] next_tag;

  always_comb begin
    base_tag    = restart ? '0 : acc;
    base_digits = restart ? '0 : digits;
    is_digit    = (data >= 8'h30) && (data <= 8'h39);
    ovf         = (base_digits == CNT_W'(MAX_TAG_DIGITS));
    empty       = (base_digits == '0);
    tag         = base_tag;
    next_tag    = base_tag * TAG_W'(10) + TAG_W'(data[3:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      digits <= '0;
    end else if (load) begin
      acc    <= next_tag;
      digits <= base_digits + CNT_W'(1);
    end else if (clear) begin
      acc    <= '0;
      digits <= '0;
    end
  end

endmodule

// File: rtl/fix_field_parser.sv
// FIX tag/value stream parser: binary tag numbers, value bytes with length,
// field-end and error beats, and a running mod-256 checksum since SOF.
module fix_field_parser
  import fix_pkg::*;
#(
  parameter int         TAG_W          = 17,
  parameter int         MAX_TAG_DIGITS = 5,
  parameter int         VLEN_W         = 8,
  parameter int         MAX_VAL_LEN    = 255,
  parameter logic [7:0] SOH_C          = SOH_DEF,
  parameter logic [7:0] SEP_C          = SEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [7:0]        out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [VLEN_W-1:0] out_vlen,
  output logic [2:0]        out_err,
  output logic [7:0]        out_sum
);

  state_e            state;
  state_e            st_eff;
  state_e            nstate;
  logic [VLEN_W-1:0] vlen;
  logic [VLEN_W-1:0] vlen_eff;
  logic [VLEN_W-1:0] vlen_nxt;
  logic [VLEN_W-1:0] bvlen;
  logic [7:0]        bdata;
  logic [2:0]        err;
  kind_e             kind;
  logic              beat;
  logic              accept;
  logic              acc_load;
  logic              acc_clear;
  logic              is_digit;
  logic              tag_ovf;
  logic              tag_empty;
  logic [TAG_W-1:0]  acc_tag;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  fix_tag_accum #(
    .TAG_W          (TAG_W),
    .MAX_TAG_DIGITS (MAX_TAG_DIGITS)
  ) u_tag (
    .clk      (clk),
    .rst      (rst),
    .restart  (in_sof),
    .load     (accept && acc_load),
    .clear    (accept && acc_clear),
    .data     (in_data),
    .is_digit (is_digit),
    .ovf      (tag_ovf),
    .empty    (tag_empty),
    .tag      (acc_tag)
  );

  // An SOF byte is decoded as if the parser were already in TAG with a fresh field.
  always_comb begin
    st_eff    = in_sof ? TAG : state;
    vlen_eff  = in_sof ? '0 : vlen;
    nstate    = st_eff;
    beat      = 1'b0;
    kind      = VALUE_BYTE;
    err       = ERR_NONE;
    bdata     = '0;
    bvlen     = vlen_eff;
    vlen_nxt  = vlen_eff;
    acc_load  = 1'b0;
    acc_clear = in_sof;
    unique case (st_eff)
      IDLE: ;
      TAG: begin
        if (is_digit) begin
          if (tag_ovf) begin
            beat   = 1'b1;
            kind   = ERROR;
            err    = ERR_TAG_OVF;
            nstate = ERR;
          end else begin
            acc_load = 1'b1;
          end
        end else if (in_data == SEP_C) begin
          beat = 1'b1;
          if (tag_empty) begin
            kind   = ERROR;
            err    = ERR_EMPTY_TAG;
            nstate = ERR;
          end else begin
            kind   = TAG_DONE;
            bvlen  = '0;
            nstate = VALUE;
          end
        end else begin
          beat   = 1'b1;
          kind   = ERROR;
          err    = ERR_BAD_TAG;
          nstate = ERR;
        end
      end
      VALUE: begin
        beat = 1'b1;
        if (in_data != SOH_C) begin
          if (vlen_eff == VLEN_W'(MAX_VAL_LEN)) begin
            kind   = ERROR;
            err    = ERR_VAL_OVF;
            nstate = ERR;
          end else begin
            vlen_nxt = vlen_eff + VLEN_W'(1);
            bvlen    = vlen_nxt;
            bdata    = in_data;
          end
        end else begin
          kind      = (vlen_eff == '0) ? ERROR : FIELD_END;
          err       = (vlen_eff == '0) ? ERR_EMPTY_VAL : ERR_NONE;
          acc_clear = 1'b1;
          vlen_nxt  = '0;
          nstate    = TAG;
        end
      end
      ERR: begin
        if (in_data == SOH_C) begin
          acc_clear = 1'b1;
          vlen_nxt  = '0;
          nstate    = TAG;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vlen      <= '0;
      out_valid <= 1'b0;
      out_kind  <= '0;
      out_data  <= '0;
      out_tag   <= '0;
      out_vlen  <= '0;
      out_err   <= '0;
      out_sum   <= '0;
    end else if (accept) begin
      state     <= nstate;
      vlen      <= vlen_nxt;
      out_valid <= beat;
      out_sum   <= in_sof ? in_data : out_sum + in_data;
      if (beat) begin
        out_kind <= kind;
        out_data <= bdata;
        out_tag  <= acc_tag;
        out_vlen <= bvlen;
        out_err  <= err;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fix_field_parser.sv
// Scoreboard bench for fix_field_parser: a behavioural model queues expected
// beats as bytes are accepted; a monitor pops and compares each delivered beat.
module tb_fix_field_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_kind;
  logic [7:0]  out_data;
  logic [16:0] out_tag;
  logic [7:0]  out_vlen;
  logic [2:0]  out_err;
  logic [7:0]  out_sum;

  fix_field_parser #(
    .TAG_W          (17),
    .MAX_TAG_DIGITS (5),
    .VLEN_W         (8),
    .MAX_VAL_LEN    (255),
    .SOH_C          (8'h01),
    .SEP_C          (8'h3D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_vlen  (out_vlen),
    .out_err   (out_err),
    .out_sum   (out_sum)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic [16:0] tag;
    logic [7:0]  vlen;
    logic [2:0]  err;
    logic [7:0]  sum;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  int   m_state = 0;  // 0 idle, 1 tag, 2 value, 3 err
  int   m_tag = 0;
  int   m_digits = 0;
  int   m_vlen = 0;
  logic [7:0] m_sum = '0;

  int   beats = 0;
  int   rdy_low = 0;
  int   cnt_kind[4];
  int   cnt_err[8];
  logic [16:0] last_tag = '0;
  logic [7:0]  last_vlen = '0;
  logic [7:0]  last_sum = '0;
  logic [1:0]  last_kind = '0;

  int   rdy_mode = 0;
  logic rdy_manual = 1'b1;

  task automatic push(input int k, input logic [7:0] d, input int e);
    exp_t x;
    x.kind = 2'(k);
    x.data = d;
    x.tag  = m_tag[16:0];
    x.vlen = m_vlen[7:0];
    x.err  = 3'(e);
    x.sum  = m_sum;
    q.push_back(x);
  endtask

  task automatic model_byte(input logic [7:0] d, input logic s);
    if (s) begin
      m_state = 1; m_tag = 0; m_digits = 0; m_vlen = 0; m_sum = d;
    end else begin
      m_sum = m_sum + d;
    end
    case (m_state)
      1: begin
        if (d >= 8'h30 && d <= 8'h39) begin
          if (m_digits == 5) begin push(3, 8'h00, 2); m_state = 3; end
          else begin m_tag = m_tag * 10 + int'(d) - 48; m_digits++; end
        end else if (d == 8'h3D) begin
          if (m_digits == 0) begin push(3, 8'h00, 1); m_state = 3; end
          else begin push(1, 8'h00, 0); m_state = 2; end
        end else begin
          push(3, 8'h00, 3); m_state = 3;
        end
      end
      2: begin
        if (d != 8'h01) begin
          if (m_vlen == 255) begin push(3, 8'h00, 4); m_state = 3; end
          else begin m_vlen++; push(0, d, 0); end
        end else begin
          if (m_vlen == 0) push(3, 8'h00, 5);
          else push(2, 8'h00, 0);
          m_tag = 0; m_digits = 0; m_vlen = 0; m_state = 1;
        end
      end
      3: begin
        if (d == 8'h01) begin m_tag = 0; m_digits = 0; m_vlen = 0; m_state = 1; end
      end
      default: ;
    endcase
  endtask

  task automatic monitor();
    exp_t        e;
    logic        hold;
    logic [46:0] saved;
    hold = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        m_state = 0; m_tag = 0; m_digits = 0; m_vlen = 0; m_sum = '0;
        hold = 1'b0;
        continue;
      end
      if (!in_ready) rdy_low++;
      if (hold) begin
        checks++;
        if ({out_valid, out_kind, out_data, out_tag, out_vlen, out_err, out_sum} !== saved) begin
          failures++;
          $display("FAIL hold_stable got=%h exp=%h", {out_valid, out_kind, out_data, out_tag,
                   out_vlen, out_err, out_sum}, saved);
        end
      end
      if (out_valid && out_ready) begin
        beats++;
        cnt_kind[out_kind]++;
        if (out_kind == 2'd3) cnt_err[out_err]++;
        last_kind = out_kind; last_tag = out_tag; last_vlen = out_vlen; last_sum = out_sum;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got kind=%0d tag=%0d vlen=%0d err=%0d exp none",
                   out_kind, out_tag, out_vlen, out_err);
        end else begin
          e = q.pop_front();
          if (out_kind !== e.kind || out_data !== e.data || out_tag !== e.tag ||
              out_vlen !== e.vlen || out_err !== e.err || out_sum !== e.sum) begin
            failures++;
            $display("FAIL beat got k=%0d d=%h t=%0d v=%0d e=%0d s=%h exp k=%0d d=%h t=%0d v=%0d e=%0d s=%h",
                     out_kind, out_data, out_tag, out_vlen, out_err, out_sum,
                     e.kind, e.data, e.tag, e.vlen, e.err, e.sum);
          end
        end
      end
      hold  = out_valid && !out_ready;
      saved = {out_valid, out_kind, out_data, out_tag, out_vlen, out_err, out_sum};
      if (in_valid && in_ready) model_byte(in_data, in_sof);
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_manual;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    int unsigned n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_sof = s;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout got in_ready=0 exp 1 byte=%h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_str(input string s, input bit sof);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h7C) c = 8'h01;
      send_byte(c, sof && (i == 0));
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0 || out_valid) begin
      failures++;
      $display("FAIL drain got pending=%0d exp 0", q.size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_kind, out_data, out_tag, out_vlen, out_err, out_sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_kind, out_data, out_tag,
               out_vlen, out_err, out_sum});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int r0, v0;
    r0 = rdy_low; v0 = cnt_kind[0];
    send_str("8=FIX.4.2|", 1'b1);
    drain();
    checks++;
    if (last_kind !== 2'd2 || last_tag !== 17'd8 || last_vlen !== 8'd7 || last_sum !== 8'h1F) begin
      failures++;
      $display("FAIL basic_field_end got k=%0d t=%0d v=%0d s=%h exp k=2 t=8 v=7 s=1f",
               last_kind, last_tag, last_vlen, last_sum);
    end
    checks++;
    if (cnt_kind[0] - v0 != 7) begin
      failures++; $display("FAIL basic_value_beats got=%0d exp=7", cnt_kind[0] - v0);
    end
    checks++;
    if (rdy_low != r0) begin
      failures++; $display("FAIL basic_in_ready got_low=%0d exp=0", rdy_low - r0);
    end
  endtask

  task automatic test_tag_ovf();
    int o0;
    o0 = cnt_err[2];
    send_str("35=D|", 1'b0);
    drain();
    checks++;
    if (last_kind !== 2'd2 || last_tag !== 17'd35 || last_vlen !== 8'd1) begin
      failures++;
      $display("FAIL ovf_field35 got k=%0d t=%0d v=%0d exp k=2 t=35 v=1", last_kind, last_tag, last_vlen);
    end
    send_str("123456=X|11=A", 1'b0);
    drain();
    checks++;
    if (cnt_err[2] - o0 != 1 || last_kind !== 2'd0 || last_tag !== 17'd11) begin
      failures++;
      $display("FAIL ovf_recover got ovf=%0d k=%0d t=%0d exp ovf=1 k=0 t=11",
               cnt_err[2] - o0, last_kind, last_tag);
    end
    send_str("|99999=Q|", 1'b0);
    drain();
    checks++;
    if (last_tag !== 17'd99999 || last_kind !== 2'd2) begin
      failures++; $display("FAIL max_digits got t=%0d k=%0d exp t=99999 k=2", last_tag, last_kind);
    end
  endtask

  task automatic test_errors();
    int e1, e3, e5, ek, fe;
    e1 = cnt_err[1]; e3 = cnt_err[3]; e5 = cnt_err[5]; ek = cnt_kind[3]; fe = cnt_kind[2];
    send_str("=5|4A=1|9=|7=Z|", 1'b0);
    drain();
    checks++;
    if (cnt_err[1] - e1 != 1 || cnt_err[3] - e3 != 1 || cnt_err[5] - e5 != 1 || cnt_kind[3] - ek != 3) begin
      failures++;
      $display("FAIL error_counts got empty_tag=%0d bad_tag=%0d empty_val=%0d total=%0d exp 1 1 1 3",
               cnt_err[1] - e1, cnt_err[3] - e3, cnt_err[5] - e5, cnt_kind[3] - ek);
    end
    checks++;
    if (cnt_kind[2] - fe != 1 || last_tag !== 17'd7) begin
      failures++;
      $display("FAIL error_recover got fe=%0d t=%0d exp fe=1 t=7", cnt_kind[2] - fe, last_tag);
    end
  endtask

  task automatic test_stall();
    int v0;
    v0 = cnt_kind[0];
    send_str("12=A", 1'b1);
    fork
      send_str("BCD|", 1'b0);
      begin
        rdy_manual = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall got in_ready=%b out_valid=%b exp 0 1", in_ready, out_valid);
          end
        end
        rdy_manual = 1'b1;
      end
    join
    drain();
    checks++;
    if (cnt_kind[0] - v0 != 4 || last_tag !== 17'd12 || last_vlen !== 8'd4) begin
      failures++;
      $display("FAIL stall_conserve got vb=%0d t=%0d v=%0d exp vb=4 t=12 v=4",
               cnt_kind[0] - v0, last_tag, last_vlen);
    end
  endtask

  task automatic test_random_ready();
    int v0, f0, e0;
    v0 = cnt_kind[0]; f0 = cnt_kind[2]; e0 = cnt_kind[3];
    rdy_mode = 1;
    send_str("55=HELLO|7=|=1|66=WORLD!|", 1'b1);
    rdy_mode = 0;
    drain();
    checks++;
    if (cnt_kind[0] - v0 != 11 || cnt_kind[2] - f0 != 2 || cnt_kind[3] - e0 != 2) begin
      failures++;
      $display("FAIL random_conserve got vb=%0d fe=%0d er=%0d exp 11 2 2",
               cnt_kind[0] - v0, cnt_kind[2] - f0, cnt_kind[3] - e0);
    end
  endtask

  task automatic test_val_ovf();
    int o0, v0;
    o0 = cnt_err[4]; v0 = cnt_kind[0];
    send_str("1=", 1'b1);
    for (int i = 0; i < 256; i++) send_byte(8'h41, 1'b0);
    send_str("|", 1'b0);
    drain();
    checks++;
    if (cnt_err[4] - o0 != 1 || cnt_kind[0] - v0 != 255 || last_vlen !== 8'd255) begin
      failures++;
      $display("FAIL val_ovf got ovf=%0d vb=%0d v=%0d exp 1 255 255",
               cnt_err[4] - o0, cnt_kind[0] - v0, last_vlen);
    end
  endtask

  task automatic test_sof_mid();
    int f0;
    f0 = cnt_kind[2];
    send_str("49=AB", 1'b0);
    send_str("8=F|", 1'b1);
    drain();
    checks++;
    if (cnt_kind[2] - f0 != 1 || last_tag !== 17'd8 || last_sum !== 8'hBC) begin
      failures++;
      $display("FAIL sof_mid got fe=%0d t=%0d s=%h exp fe=1 t=8 s=bc", cnt_kind[2] - f0, last_tag, last_sum);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    rdy_manual = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_str("44=", 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got out_valid=%b exp 1", out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_tag !== 17'd0) begin
      failures++;
      $display("FAIL rst_async got v=%b s=%h t=%0d exp 0 0 0", out_valid, out_sum, out_tag);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_manual = 1'b1;
    b0 = beats;
    send_str("5=A|", 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (beats != b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_idle_drop got beats=%0d exp 0", beats - b0);
    end
    @(posedge clk);
    #1;
    send_str("8=F|", 1'b1);
    drain();
    checks++;
    if (last_tag !== 17'd8 || last_kind !== 2'd2) begin
      failures++; $display("FAIL rst_recover got t=%0d k=%0d exp t=8 k=2", last_tag, last_kind);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cnt_kind[i] = 0;
    for (int i = 0; i < 8; i++) cnt_err[i] = 0;
    fork
      monitor();
      ready_drv();
    join_none
    test_reset();
    test_basic();
    test_tag_ovf();
    test_errors();
    test_stall();
    test_random_ready();
    test_val_ovf();
    test_sof_mid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fix_field_parser.md
Name: fix_field_parser

Overview:
- Parametrised successor to the single-byte FIX tag/value splitter.
- Consumes a FIX byte stream under valid/ready and converts each ASCII-decimal tag into a binary tag number.
- Streams value bytes with length tracking, flags field ends and protocol errors, and keeps a running mod-256 byte sum for tag-10 checksum checking downstream.
- Sits between the byte ingress (MAC/FIFO) and the message/field decoders.

Parameters:
- TAG_W, 17: width of the binary tag number; must satisfy 10^MAX_TAG_DIGITS - 1 < 2^TAG_W.
- MAX_TAG_DIGITS, 5: maximum decimal digits in a tag.
- VLEN_W, 8: width of the value-length counter.
- MAX_VAL_LEN, 255: maximum value bytes per field; must be <= 2^VLEN_W - 1.
- SOH_C, 8'h01: field terminator.
- SEP_C, 8'h3D: tag/value separator ("=").

Ports:
- clk  in  1  single clock; all flops on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  parser can accept a byte.
- in_data  in  8  input byte.
- in_sof  in  1  qualifies in_data as the first byte of a new message.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_kind  out  2  0 VALUE_BYTE, 1 TAG_DONE, 2 FIELD_END, 3 ERROR.
- out_data  out  8  value byte (VALUE_BYTE only, else 0).
- out_tag  out  TAG_W  current field's tag number.
- out_vlen  out  VLEN_W  value bytes seen so far in the field, including this beat.
- out_err  out  3  error code (ERROR beats only, else 0).
- out_sum  out  8  mod-256 sum of all accepted bytes since the SOF byte, inclusive.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - out_valid=0; out_kind, out_data, out_tag, out_vlen, out_err and out_sum all 0.
  - Tag accumulator, digit count and vlen cleared.
  - in_ready=1 once rst deasserts.
- Handshake:
  - Byte accepted when in_valid && in_ready, where in_ready = !out_valid || out_ready.
  - Each accepted byte produces 0 or 1 output beat, registered, 1-cycle latency.
  - A beat is held stable while out_valid && !out_ready.
  - Full throughput: 1 byte/cycle with out_ready=1.
- Checksum: out_sum reloads with in_data on an accepted SOF byte; otherwise it adds in_data mod 256 on every accepted byte, including dropped ones.
- in_sof=1 on any accepted byte, in any state: abandon the current field silently (no beat), clear tag/digits/vlen, then process the byte as the first byte in TAG.
- IDLE: bytes without in_sof are dropped, no beat.
- TAG:
  - Digit '0'-'9': tag = tag*10 + digit, digits++, no beat. If digits would exceed MAX_TAG_DIGITS: ERROR TAG_OVF(2), go ERR.
  - SEP_C with digits=0: ERROR EMPTY_TAG(1), go ERR.
  - SEP_C with digits>0: TAG_DONE beat (out_tag=tag, out_vlen=0), go VALUE.
  - SOH_C or any other byte: ERROR BAD_TAG(3), go ERR.
- VALUE:
  - Byte != SOH_C: vlen++, VALUE_BYTE beat with out_data=byte. If vlen would exceed MAX_VAL_LEN: ERROR VAL_OVF(4) instead, go ERR; vlen saturates.
  - SOH_C with vlen=0: ERROR EMPTY_VAL(5), go TAG (field boundary is intact).
  - SOH_C with vlen>0: FIELD_END beat (out_tag, out_vlen=final length), clear tag/digits/vlen, go TAG.
  - SEP_C inside a value is ordinary data.
- ERR: drop bytes with no beat until SOH_C, then clear and go TAG. Exactly one ERROR beat per error.
- ERROR beats carry out_tag/out_vlen as they stood at the failure.
- Error codes: 0 NONE, 1 EMPTY_TAG, 2 TAG_OVF, 3 BAD_TAG, 4 VAL_OVF, 5 EMPTY_VAL.
- Reset mid-message: immediate return to IDLE; an unaccepted output beat is discarded.

Decomposition:
- fix_pkg:
  - out_kind enum (VALUE_BYTE/TAG_DONE/FIELD_END/ERROR).
  - Error-code constants.
  - SOH/SEP defaults.
  - State enum (IDLE/TAG/VALUE/ERR).
- One sub-module, fix_tag_accum: decimal digit detect, tag*10+digit accumulate, digit count and overflow flag; parameters TAG_W, MAX_TAG_DIGITS.
- FSM, vlen, checksum and the output register stay in fix_field_parser.

Test Plan:
- "8=FIX.4.2<SOH>" with sof on '8', out_ready=1:
  - TAG_DONE tag=8.
  - 7 VALUE_BYTE beats, vlen 1..7.
  - FIELD_END tag=8 vlen=7, out_sum=0x1F.
  - in_ready never drops.
- "35=D<SOH>" then "123456=X<SOH>": FIELD_END tag=35 vlen=1, then ERROR TAG_OVF on the 6th digit, 'X' dropped, then TAG state (next "11=A<SOH>" gives TAG_DONE tag=11).
- Cases "=5<SOH>", "4A=1<SOH>", "9=<SOH>": ERROR EMPTY_TAG, BAD_TAG and EMPTY_VAL respectively, exactly one beat each, parser recovers on the following field.
- out_ready held 0 for 5 cycles during a value: in_ready=0 after the first beat, beat held stable, no byte lost or duplicated; byte count conserved when out_ready toggles randomly.
- sof asserted mid-value ("49=AB" then sof "8=F<SOH>"): no FIELD_END for tag 49, TAG_DONE tag=8, out_sum restarts from 0x38.
- rst pulsed low mid-field with out_valid=1: out_valid falls asynchronously, state IDLE, a subsequent non-sof byte is dropped.
